// File: rtl/ch_cfg_spi_bridge.sv
// ---------------------------------------------------------------------------
// ch_cfg_spi_bridge
//   SPI slave (mode 0, MSB first) that turns framed writes from the
//   front-panel MCU into one-cycle register-write strobes for the per-channel
//   register-config blocks.
//
//   Frame: byte0 header {AINC, 3'b000, CH[3:0]}, byte1 start address,
//          byte2..N data bytes (one write each).
//
// Ports:
//   CLK_LOW          system low-speed clock
//   reset_n          asynchronous active-low reset
//   SPI_CS_N         chip select, active-low (asynchronous)
//   SPI_SCK          SPI clock, idle low (asynchronous, <= CLK_LOW/4)
//   SPI_MOSI         serial data, sampled on SCK rising edge
//   ERR_CLR          synchronous clear of FRAME_ERR
//   CH_CONFIG_WE     per-channel write strobe (one cycle)
//   CH_CONFIG_ADDR   register address, held until next write
//   CH_CONFIG_DATA   register data, held until next write
//   FRAME_ERR        sticky header decode error
//   BUSY             synchronized chip select, inverted
//
// Build option:
//   CH_CFG_BROADCAST_EN - header CH = 4'hF writes all channels at once.
//                         Without it CH = 4'hF is a decode error.
// ---------------------------------------------------------------------------
module ch_cfg_spi_bridge #(
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK_LOW,
    input  logic              reset_n,
    input  logic              SPI_CS_N,
    input  logic              SPI_SCK,
    input  logic              SPI_MOSI,
    input  logic              ERR_CLR,
    output logic [NUM_CH-1:0] CH_CONFIG_WE,
    output logic [7:0]        CH_CONFIG_ADDR,
    output logic [7:0]        CH_CONFIG_DATA,
    output logic              FRAME_ERR,
    output logic              BUSY
);

    localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_DATA,
        ST_DISCARD
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] rdy_q;
    logic                   cs_s, sck_s, mosi_s, sync_rdy, sck_rise;

    logic                   sck_prev_q;
    logic [7:0]             shift_q;
    logic [2:0]             bitcnt_q;
    logic                   byte_vld_q;

    state_t                 state_q;
    logic                   ainc_q;
    logic                   bcast_q;
    logic [3:0]             ch_q;
    logic [7:0]             addr_q;
    logic [NUM_CH-1:0]      we_q;
    logic [NUM_CH-1:0]      we_d;
    logic [7:0]             waddr_q;
    logic [7:0]             wdata_q;
    logic                   err_q;

    logic [3:0]             hdr_ch;
    logic                   hdr_bcast;
    logic                   hdr_bad;

    // Stage 0: input synchronizers. CS resets high so BUSY reads 0 in reset.
    // rdy_q flags when the chains hold real pin samples rather than reset
    // values, so a frame already running at reset release stays discarded.
    always_ff @(posedge CLK_LOW or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            rdy_q       <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS_N};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SPI_SCK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
            rdy_q       <= {rdy_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sync_rdy = rdy_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q & ~cs_s;

    // Stage 1: bit counter and byte-complete strobe.
    always_ff @(posedge CLK_LOW or negedge reset_n) begin
        if (!reset_n) begin
            sck_prev_q <= 1'b0;
            bitcnt_q   <= 3'd0;
            byte_vld_q <= 1'b0;
        end else begin
            sck_prev_q <= sck_s;
            byte_vld_q <= 1'b0;
            if (cs_s) begin
                bitcnt_q <= 3'd0;
            end else if (sck_rise) begin
                bitcnt_q   <= bitcnt_q + 3'd1;
                byte_vld_q <= (bitcnt_q == 3'd7);
            end
        end
    end

    always_ff @(posedge CLK_LOW) begin
        if (sck_rise) begin
            shift_q <= {shift_q[6:0], mosi_s};
        end
    end

    // Header decode, evaluated on the completed byte in shift_q.
    assign hdr_ch = shift_q[3:0];
`ifdef CH_CFG_BROADCAST_EN
    assign hdr_bcast = (hdr_ch == 4'hF);
`else
    assign hdr_bcast = 1'b0;
`endif
    assign hdr_bad = (shift_q[6:4] != 3'b000) ||
                     (!hdr_bcast && ({1'b0, hdr_ch} >= NUM_CH_W));

    always_comb begin
        we_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            we_d[i] = bcast_q | (ch_q == 4'(i));
        end
    end

    // Stage 2: frame FSM with registered write outputs.
    always_ff @(posedge CLK_LOW or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_DISCARD;
            ainc_q  <= 1'b0;
            bcast_q <= 1'b0;
            ch_q    <= 4'd0;
            addr_q  <= 8'd0;
            we_q    <= '0;
            waddr_q <= 8'd0;
            wdata_q <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            we_q <= '0;
            if (ERR_CLR) begin
                err_q <= 1'b0;
            end
            if (cs_s && sync_rdy) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!cs_s) begin
                            state_q <= ST_HDR;
                        end
                    end
                    ST_HDR: begin
                        if (byte_vld_q) begin
                            if (hdr_bad) begin
                                err_q   <= 1'b1;  // set wins over ERR_CLR
                                state_q <= ST_DISCARD;
                            end else begin
                                ainc_q  <= shift_q[7];
                                ch_q    <= hdr_ch;
                                bcast_q <= hdr_bcast;
                                state_q <= ST_ADDR;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (byte_vld_q) begin
                            addr_q  <= shift_q;
                            state_q <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (byte_vld_q) begin
                            we_q    <= we_d;
                            waddr_q <= addr_q;
                            wdata_q <= shift_q;
                            if (ainc_q) begin
                                addr_q <= addr_q + 8'd1;
                            end
                        end
                    end
                    ST_DISCARD: begin
                        state_q <= ST_DISCARD;
                    end
                    default: begin
                        state_q <= ST_DISCARD;
                    end
                endcase
            end
        end
    end

    assign CH_CONFIG_WE   = we_q;
    assign CH_CONFIG_ADDR = waddr_q;
    assign CH_CONFIG_DATA = wdata_q;
    assign FRAME_ERR      = err_q;
    assign BUSY           = ~cs_s;

endmodule

// File: tb/tb_ch_cfg_spi_bridge.sv
// ---------------------------------------------------------------------------
// tb_ch_cfg_spi_bridge
//   Directed bench for ch_cfg_spi_bridge (NUM_CH=2, SYNC_STAGES=2). Expected
//   writes are queued as data bytes are driven; a monitor pops and compares
//   each write strobe and checks strobe width.
// ---------------------------------------------------------------------------
module tb_ch_cfg_spi_bridge;

    localparam int NUM_CH = 2;

    logic              CLK_LOW = 1'b0;
    logic              reset_n;
    logic              SPI_CS_N;
    logic              SPI_SCK;
    logic              SPI_MOSI;
    logic              ERR_CLR;
    logic [NUM_CH-1:0] CH_CONFIG_WE;
    logic [7:0]        CH_CONFIG_ADDR;
    logic [7:0]        CH_CONFIG_DATA;
    logic              FRAME_ERR;
    logic              BUSY;

    typedef struct {
        logic [NUM_CH-1:0] we;
        logic [7:0]        addr;
        logic [7:0]        data;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              mon_e;
    logic [NUM_CH-1:0] prev_we = '0;
    int                n_cmp   = 0;
    int                n_err   = 0;

    ch_cfg_spi_bridge #(.NUM_CH(NUM_CH), .SYNC_STAGES(2)) dut (
        .CLK_LOW        (CLK_LOW),
        .reset_n        (reset_n),
        .SPI_CS_N       (SPI_CS_N),
        .SPI_SCK        (SPI_SCK),
        .SPI_MOSI       (SPI_MOSI),
        .ERR_CLR        (ERR_CLR),
        .CH_CONFIG_WE   (CH_CONFIG_WE),
        .CH_CONFIG_ADDR (CH_CONFIG_ADDR),
        .CH_CONFIG_DATA (CH_CONFIG_DATA),
        .FRAME_ERR      (FRAME_ERR),
        .BUSY           (BUSY)
    );

    always #5 CLK_LOW = ~CLK_LOW;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK_LOW);
    endtask

    // SCK = CLK_LOW/8; MOSI changes only while SCK is low.
    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            SPI_MOSI = b[i];
            wait_clk(4);
            SPI_SCK = 1'b1;
            wait_clk(4);
            SPI_SCK = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic expect_wr(input logic [NUM_CH-1:0] we, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.we   = we;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic cs_low();
        SPI_CS_N = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_high();
        wait_clk(8);
        SPI_CS_N = 1'b1;
        wait_clk(8);
    endtask

    // Scoreboard monitor: every strobe must match the head of the queue and
    // last exactly one cycle.
    always @(negedge CLK_LOW) begin
        if (reset_n === 1'b1) begin
            if (prev_we != '0) begin
                check("we_gap", 32'(CH_CONFIG_WE), 32'd0);
            end
            if (CH_CONFIG_WE != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_we", 32'(CH_CONFIG_WE), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("we",   32'(CH_CONFIG_WE),   32'(mon_e.we));
                    check("addr", 32'(CH_CONFIG_ADDR), 32'(mon_e.addr));
                    check("data", 32'(CH_CONFIG_DATA), 32'(mon_e.data));
                end
            end
        end
        prev_we = CH_CONFIG_WE;
    end

    initial begin
        reset_n  = 1'b0;
        SPI_CS_N = 1'b1;
        SPI_SCK  = 1'b0;
        SPI_MOSI = 1'b0;
        ERR_CLR  = 1'b0;
        wait_clk(3);
        check("rst_we",   32'(CH_CONFIG_WE),   32'd0);
        check("rst_addr", 32'(CH_CONFIG_ADDR), 32'd0);
        check("rst_data", 32'(CH_CONFIG_DATA), 32'd0);
        check("rst_err",  32'(FRAME_ERR),      32'd0);
        check("rst_busy", 32'(BUSY),           32'd0);
        reset_n = 1'b1;
        wait_clk(6);

        // Frequency bytes 0x03..0x08 on channel 0, auto-increment.
        cs_low();
        wait_clk(2);
        check("busy_active", 32'(BUSY), 32'd1);
        send_byte(8'h80);
        send_byte(8'h03);
        for (int i = 0; i < 6; i++) begin
            expect_wr(2'b01, 8'h03 + 8'(i), 8'h11 * 8'(i + 1));
            send_byte(8'h11 * 8'(i + 1));
        end
        cs_high();
        check("busy_idle", 32'(BUSY), 32'd0);
        check("q_empty_1", 32'(exp_q.size()), 32'd0);

        // Channel 1, no auto-increment.
        cs_low();
        send_byte(8'h01);
        send_byte(8'h2D);
        expect_wr(2'b10, 8'h2D, 8'h01);
        send_byte(8'h01);
        expect_wr(2'b10, 8'h2D, 8'h00);
        send_byte(8'h00);
        cs_high();
        check("q_empty_2", 32'(exp_q.size()), 32'd0);
        check("hold_addr", 32'(CH_CONFIG_ADDR), 32'h2D);
        check("hold_data", 32'(CH_CONFIG_DATA), 32'h00);

        // Address wrap 0xFF -> 0x00.
        cs_low();
        send_byte(8'h80);
        send_byte(8'hFF);
        expect_wr(2'b01, 8'hFF, 8'hAA);
        send_byte(8'hAA);
        expect_wr(2'b01, 8'h00, 8'hBB);
        send_byte(8'hBB);
        cs_high();
        check("q_empty_3", 32'(exp_q.size()), 32'd0);

        // Out-of-range channel: no write, sticky error, cleared by ERR_CLR.
        cs_low();
        send_byte(8'h05);
        send_byte(8'h40);
        send_byte(8'h01);
        cs_high();
        check("err_set_ch", 32'(FRAME_ERR), 32'd1);
        ERR_CLR = 1'b1;
        wait_clk(1);
        ERR_CLR = 1'b0;
        wait_clk(1);
        check("err_clr", 32'(FRAME_ERR), 32'd0);

        // Non-zero reserved header bits.
        cs_low();
        send_byte(8'h10);
        send_byte(8'h40);
        send_byte(8'h01);
        cs_high();
        check("err_set_rsvd", 32'(FRAME_ERR), 32'd1);
        ERR_CLR = 1'b1;
        wait_clk(1);
        ERR_CLR = 1'b0;
        wait_clk(1);
        check("err_clr2", 32'(FRAME_ERR), 32'd0);

        // CS released mid-byte: partial byte dropped, no error.
        cs_low();
        send_byte(8'h80);
        send_byte(8'h31);
        send_bits(8'h0F, 5);
        cs_high();
        check("partial_err", 32'(FRAME_ERR), 32'd0);
        cs_low();
        send_byte(8'h00);
        send_byte(8'h31);
        expect_wr(2'b01, 8'h31, 8'h07);
        send_byte(8'h07);
        cs_high();
        check("q_empty_4", 32'(exp_q.size()), 32'd0);

        // Header + address only: no write, no error.
        cs_low();
        send_byte(8'h81);
        send_byte(8'h50);
        cs_high();
        check("hdr_addr_err", 32'(FRAME_ERR), 32'd0);

        // Reset mid-frame with CS held low: remainder of frame ignored.
        cs_low();
        send_byte(8'h80);
        send_byte(8'h03);
        reset_n = 1'b0;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(4);
        send_byte(8'h80);
        send_byte(8'h10);
        send_byte(8'h33);
        cs_high();
        check("rst_frame_err", 32'(FRAME_ERR), 32'd0);
        check("rst_frame_addr", 32'(CH_CONFIG_ADDR), 32'd0);
        cs_low();
        send_byte(8'h80);
        send_byte(8'h10);
        expect_wr(2'b01, 8'h10, 8'h5A);
        send_byte(8'h5A);
        cs_high();
        check("q_empty_5", 32'(exp_q.size()), 32'd0);

        // Broadcast header CH=0xF.
        cs_low();
        send_byte(8'h8F);
        send_byte(8'h5A);
`ifdef CH_CFG_BROADCAST_EN
        expect_wr(2'b11, 8'h5A, 8'h01);
`endif
        send_byte(8'h01);
        cs_high();
`ifdef CH_CFG_BROADCAST_EN
        check("bcast_err", 32'(FRAME_ERR), 32'd0);
`else
        check("bcast_err", 32'(FRAME_ERR), 32'd1);
`endif
        check("q_empty_6", 32'(exp_q.size()), 32'd0);

        wait_clk(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
